irq_arbiter: RTL and testbench



---
 rtl/irq_arbiter.sv | 115 +++++++++++
 tb/tb_irq_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_arbiter.sv
// Priority interrupt arbiter feeding cp0: edge-latched pending bits, per-source 2-bit priority,
// nested service tracking through a 3-entry level stack. Define IRQ_LEVEL_TRIG_EN for level-sensitive sources.
module irq_arbiter #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             cfg_we,
    input  logic [ID_W-1:0]  cfg_addr,
    input  logic [1:0]       cfg_wdata,
    output logic [1:0]       cfg_rdata,
    input  logic             take,
    input  logic             eret,
    output logic [2:0]       irq_level,
    output logic [ID_W-1:0]  irq_id,
    output logic [2:0]       cur_level,
    output logic [1:0]       depth,
    output logic [N_SRC-1:0] pending
);

    logic [N_SRC-1:0] irq_q;
    logic [1:0]       prio [N_SRC];
    logic [2:0][2:0]  stack;          // stack[0] is the most recently pushed level

    logic             win_valid;
    logic [1:0]       win_prio;
    logic [ID_W-1:0]  win_id;
    logic [N_SRC-1:0] clr_vec;
    logic [N_SRC-1:0] pending_next;
    logic             do_take;
    logic             do_eret;

    // eret wins over a simultaneous take; the untaken request is re-presented later.
    assign do_eret = eret && (depth != 2'd0);
    assign do_take = take && !eret && (irq_level != 3'd0);

    // NOTE: every variable in this block gets a default first, so no latch is inferred.
    always_comb begin
        win_valid = 1'b0;
        win_prio  = 2'd0;
        win_id    = '0;
        cfg_rdata = 2'd0;
        clr_vec   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            // Strict '>' keeps the lowest index on a tie.
            if (pending[i] && ({1'b0, prio[i]} > cur_level) && (prio[i] > win_prio)) begin
                win_valid = 1'b1;
                win_prio  = prio[i];
                win_id    = ID_W'(i);
            end
            if (cfg_addr == ID_W'(i)) begin
                cfg_rdata = prio[i];
            end
            if (do_take && (irq_id == ID_W'(i))) begin
                clr_vec[i] = 1'b1;
            end
        end
    end

`ifdef IRQ_LEVEL_TRIG_EN
    assign pending_next = irq_in;
`else
    // A new edge in the same cycle as the take-clear keeps the bit set.
    assign pending_next = (pending & ~clr_vec) | (irq_in & ~irq_q);
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q     <= '0;
            pending   <= '0;
            irq_level <= 3'd0;
            irq_id    <= '0;
            cur_level <= 3'd0;
            depth     <= 2'd0;
            stack     <= '0;
            // NOTE: the priority table is small and must come up masked, so it is reset like any register.
            for (int i = 0; i < N_SRC; i++) begin
                prio[i] <= 2'd0;
            end
        end else begin
            irq_q   <= irq_in;
            pending <= pending_next;

            if (cfg_we) begin
                for (int i = 0; i < N_SRC; i++) begin
                    if (cfg_addr == ID_W'(i)) begin
                        prio[i] <= cfg_wdata;
                    end
                end
            end

            // Both handshakes blank irq_level for one cycle so arbitration sees the new cur_level.
            if (do_eret) begin
                cur_level <= stack[0];
                stack     <= {3'd0, stack[2:1]};
                depth     <= depth - 2'd1;
                irq_level <= 3'd0;
            end else if (do_take) begin
                stack     <= {stack[1:0], cur_level};
                depth     <= depth + 2'd1;
                cur_level <= irq_level;
                irq_level <= 3'd0;
            end else if (win_valid) begin
                irq_level <= {1'b0, win_prio};
                irq_id    <= win_id;
            end else begin
                irq_level <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed self-checking bench for irq_arbiter (N_SRC=8, ID_W=4); inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_irq_arbiter;

    localparam int N_SRC = 8;
    localparam int ID_W  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_SRC-1:0] irq_in;
    logic             cfg_we;
    logic [ID_W-1:0]  cfg_addr;
    logic [1:0]       cfg_wdata;
    logic [1:0]       cfg_rdata;
    logic             take;
    logic             eret;
    logic [2:0]       irq_level;
    logic [ID_W-1:0]  irq_id;
    logic [2:0]       cur_level;
    logic [1:0]       depth;
    logic [N_SRC-1:0] pending;

    int total = 0;
    int bad   = 0;

    irq_arbiter #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .take(take), .eret(eret),
        .irq_level(irq_level), .irq_id(irq_id), .cur_level(cur_level),
        .depth(depth), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int addr, input int data);
        cfg_we    = 1'b1;
        cfg_addr  = ID_W'(addr);
        cfg_wdata = 2'(data);
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic pulse_irq(input logic [N_SRC-1:0] lines);
        irq_in = lines;
        step();
        irq_in = '0;
    endtask

    task automatic do_take();
        take = 1'b1;
        step();
        take = 1'b0;
    endtask

    task automatic do_eret();
        eret = 1'b1;
        step();
        eret = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        take = 1'b0; eret = 1'b0;
        step(); step();
        rst = 1'b0;
        check("rst_level", irq_level, 0);
        check("rst_id", irq_id, 0);
        check("rst_cur", cur_level, 0);
        check("rst_depth", depth, 0);
        check("rst_pending", pending, 0);
        check("rst_rdata", cfg_rdata, 0);

`ifdef IRQ_LEVEL_TRIG_EN
        cfg(4, 1);
        irq_in = 8'h10;
        step(); step();
        check("lvl_present", irq_level, 1);
        check("lvl_id", irq_id, 4);
        do_take();
        check("lvl_take_level", irq_level, 0);
        check("lvl_take_cur", cur_level, 1);
        step();
        check("lvl_blocked", irq_level, 0);
        check("lvl_pend_held", pending, 8'h10);
        do_eret();
        check("lvl_eret_gap", irq_level, 0);
        step();
        check("lvl_represent", irq_level, 1);
        irq_in = '0;
        step(); step();
        check("lvl_dropped", irq_level, 0);
        check("lvl_pend_clear", pending, 0);
`else
        // Single source: latency and take.
        cfg(3, 2);
        check("rdata3", cfg_rdata, 2);
        pulse_irq(8'h08);
        check("t1_pending", pending, 8'h08);
        check("t1_not_yet", irq_level, 0);
        step();
        check("t1_level", irq_level, 2);
        check("t1_id", irq_id, 3);
        do_take();
        check("t1_cur", cur_level, 2);
        check("t1_depth", depth, 1);
        check("t1_pend_clr", pending, 0);
        check("t1_level_gap", irq_level, 0);
        do_eret();
        check("t1_eret_depth", depth, 0);

        // Tie-break and blocking at equal level.
        cfg(1, 2); cfg(5, 2); cfg(6, 1);
        pulse_irq(8'h62);
        check("t2_pending", pending, 8'h62);
        step();
        check("t2_level", irq_level, 2);
        check("t2_id", irq_id, 1);
        do_take();
        check("t2_pend", pending, 8'h60);
        step();
        check("t2_blocked", irq_level, 0);
        check("t2_id_hold", irq_id, 1);
        do_eret();
        check("t2_eret_cur", cur_level, 0);
        step();
        check("t2_src5_level", irq_level, 2);
        check("t2_src5_id", irq_id, 5);
        do_take();
        do_eret();
        step();
        check("t2_src6_id", irq_id, 6);
        check("t2_src6_level", irq_level, 1);
        do_take();
        check("t3_cur1", cur_level, 1);

        // Nesting a level-3 source over the level-1 service.
        cfg(7, 3);
        pulse_irq(8'h80);
        step();
        check("t3_nest_level", irq_level, 3);
        check("t3_nest_id", irq_id, 7);
        do_take();
        check("t3_depth2", depth, 2);
        check("t3_cur3", cur_level, 3);
        do_eret();
        check("t3_pop_cur1", cur_level, 1);
        check("t3_pop_depth1", depth, 1);
        do_eret();
        check("t3_pop_cur0", cur_level, 0);
        check("t3_pop_depth0", depth, 0);
        do_eret();
        check("t3_extra_cur", cur_level, 0);
        check("t3_extra_depth", depth, 0);

        // take and eret together.
        pulse_irq(8'h40);
        step();
        do_take();
        pulse_irq(8'h08);
        step();
        check("t4_pre_level", irq_level, 2);
        check("t4_pre_depth", depth, 1);
        take = 1'b1; eret = 1'b1;
        step();
        take = 1'b0; eret = 1'b0;
        check("t4_depth", depth, 0);
        check("t4_cur", cur_level, 0);
        check("t4_pending", pending, 8'h08);
        step();
        check("t4_represent", irq_level, 2);
        check("t4_id", irq_id, 3);

        // New edge coinciding with the take-clear keeps pending set.
        take = 1'b1; irq_in = 8'h08;
        step();
        take = 1'b0; irq_in = '0;
        check("t5_set_wins", pending, 8'h08);
        check("t5_cur", cur_level, 2);
        do_eret();
        step();
        do_take();
        do_eret();
        check("t5_clean", pending, 0);

        // Masked source, then unmask.
        cfg(2, 0);
        pulse_irq(8'h04);
        step();
        check("t6_masked_pend", pending, 8'h04);
        check("t6_masked_level", irq_level, 0);
        cfg(2, 3);
        check("t6_wr_plus1", irq_level, 0);
        step();
        check("t6_unmask_level", irq_level, 3);
        check("t6_unmask_id", irq_id, 2);
        cfg(12, 3);
        check("t6_oob_rdata", cfg_rdata, 0);
        cfg_addr = 4'd4;
        #1;
        check("t6_rdata4", cfg_rdata, 0);
        do_take();
        check("t6_depth", depth, 1);
`endif

        // Reset in service.
        irq_in = 8'h01;
        rst = 1'b1;
        step();
        rst = 1'b0;
        irq_in = '0;
        check("rst2_level", irq_level, 0);
        check("rst2_id", irq_id, 0);
        check("rst2_cur", cur_level, 0);
        check("rst2_depth", depth, 0);
        check("rst2_pending", pending, 0);
        cfg_addr = 4'd2;
        #1;
        check("rst2_prio", cfg_rdata, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
